// File: rtl/alu_group_encoder.sv
// Encodes ALU operation requests into Group 3 instruction words and buffers them
// in a small FIFO with valid/ready handshakes on both sides.
module alu_group_encoder #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] RA_REG     = 4'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  REQ_OP,
  input  logic [3:0]  REQ_DST,
  input  logic        REQ_IMM,
  input  logic [3:0]  REQ_SRC,
  input  logic [15:0] REQ_DATA,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [15:0] INSTRUCTION,
  output logic        REJECT,
  output logic [7:0]  REJECT_CNT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ARGF_REG_REG = 2'b00,
    ARGF_REG_U4  = 2'b01,
    ARGF_REGA_U8 = 2'b10,
    ARGF_REGA_S8 = 2'b11
  } argf_e;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             reject_q, reject_d;
  logic [7:0]       reject_cnt_q, reject_cnt_d;

  argf_e       argf;
  logic [7:0]  operand;
  logic        encodable;
  logic [15:0] word;
  logic        full;
  logic        req_xfer;
  logic        push;
  logic        pop;

  // First matching rule wins: register form, short immediate, then RA-only byte forms.
  always_comb begin
    argf      = ARGF_REG_REG;
    operand   = {REQ_DST, REQ_SRC};
    encodable = 1'b1;
    if (!REQ_IMM) begin
      argf    = ARGF_REG_REG;
      operand = {REQ_DST, REQ_SRC};
    end else if (REQ_DATA[15:4] == 12'h000) begin
      argf    = ARGF_REG_U4;
      operand = {REQ_DST, REQ_DATA[3:0]};
    end else if (REQ_DST == RA_REG && REQ_DATA[15:8] == 8'h00) begin
      argf    = ARGF_REGA_U8;
      operand = REQ_DATA[7:0];
    end else if (REQ_DST == RA_REG && REQ_DATA[15:7] == 9'h1FF) begin
      argf    = ARGF_REGA_S8;
      operand = REQ_DATA[7:0];
    end else begin
      encodable = 1'b0;
      operand   = 8'h00;
    end
  end

  assign word        = {2'b11, REQ_OP, argf, operand};
  assign full        = (count_q == FULL_CNT);
  assign REQ_READY   = !full && !FLUSH;
  assign req_xfer    = REQ_VALID && REQ_READY;
  assign push        = req_xfer && encodable;
  assign INSTR_VALID = (count_q != '0);
  assign pop         = INSTR_VALID && INSTR_READY;
  assign INSTRUCTION = INSTR_VALID ? mem_q[rd_ptr_q] : 16'h0000;
  assign REJECT      = reject_q;
  assign REJECT_CNT  = reject_cnt_q;

  // FLUSH takes precedence over any same-cycle push or pop.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    reject_d     = 1'b0;
    reject_cnt_d = reject_cnt_q;
    if (FLUSH) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      reject_cnt_d = 8'h00;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = word;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      reject_d = req_xfer && !encodable;
      if (reject_d && reject_cnt_q != 8'hFF) begin
        reject_cnt_d = reject_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reject_q     <= 1'b0;
      reject_cnt_q <= 8'h00;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reject_q     <= reject_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_group_encoder.sv
// Directed self-checking bench for alu_group_encoder: encoding modes, rejects,
// backpressure ordering, FLUSH and mid-stream RESET.
module tb_alu_group_encoder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FLUSH = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [3:0]  REQ_OP = 4'd0;
  logic [3:0]  REQ_DST = 4'd0;
  logic        REQ_IMM = 1'b0;
  logic [3:0]  REQ_SRC = 4'd0;
  logic [15:0] REQ_DATA = 16'h0000;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [15:0] INSTRUCTION;
  logic        REJECT;
  logic [7:0]  REJECT_CNT;

  int assertCount = 0;
  int failCount   = 0;

  alu_group_encoder #(.FIFO_DEPTH(4), .RA_REG(4'd0)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_DST(REQ_DST), .REQ_IMM(REQ_IMM),
    .REQ_SRC(REQ_SRC), .REQ_DATA(REQ_DATA),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .INSTRUCTION(INSTRUCTION),
    .REJECT(REJECT), .REJECT_CNT(REJECT_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setRequest(input logic [3:0] dst, input logic imm, input logic [3:0] src, input logic [15:0] data);
    REQ_OP   = 4'd2;
    REQ_DST  = dst;
    REQ_IMM  = imm;
    REQ_SRC  = src;
    REQ_DATA = data;
  endtask

  // Holds the request until it transfers, then returns #1 after that edge.
  task automatic applyStimulus(input logic [3:0] dst, input logic imm, input logic [3:0] src, input logic [15:0] data);
    int waited = 0;
    @(negedge CLK);
    setRequest(dst, imm, src, data);
    REQ_VALID = 1'b1;
    while (!REQ_READY && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 50) checkOutput("req_ready_timeout", 0, 1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic expectPop(input string tag, input logic [15:0] expected);
    checkOutput({tag, "_valid"}, {31'd0, INSTR_VALID}, 1);
    checkOutput({tag, "_word"}, {16'd0, INSTRUCTION}, {16'd0, expected});
    @(negedge CLK);
    INSTR_READY = 1'b1;
    @(posedge CLK);
    #1;
    INSTR_READY = 1'b0;
  endtask

  initial begin
    logic [15:0] seq [6];
    $display("[TB] start");
    #12;
    checkOutput("rst_valid", {31'd0, INSTR_VALID}, 0);
    checkOutput("rst_instr", {16'd0, INSTRUCTION}, 0);
    checkOutput("rst_reject", {31'd0, REJECT}, 0);
    checkOutput("rst_rejcnt", {24'd0, REJECT_CNT}, 0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checkOutput("rst_ready", {31'd0, REQ_READY}, 1);

    // T1 / T2 / T3: each word visible right after its accepting edge
    applyStimulus(4'd3, 1'b0, 4'd5, 16'd0);
    expectPop("t1_regreg", 16'hC835);
    checkOutput("t1_empty_instr", {16'd0, INSTRUCTION}, 0);
    applyStimulus(4'd3, 1'b1, 4'd0, 16'd9);
    expectPop("t2_u4", 16'hC939);
    applyStimulus(4'd0, 1'b1, 4'd0, 16'd10);
    expectPop("t2_u4_ra", 16'hC90A);
    applyStimulus(4'd0, 1'b1, 4'd0, 16'd200);
    expectPop("t3_u8", 16'hCAC8);
    applyStimulus(4'd0, 1'b1, 4'd0, 16'hFF80);
    expectPop("t3_s8_min", 16'hCB80);
    applyStimulus(4'd0, 1'b1, 4'd0, 16'hFFFF);
    expectPop("t3_s8_max", 16'hCBFF);

    // T4: rejects
    applyStimulus(4'd3, 1'b1, 4'd0, 16'd200);
    checkOutput("t4_reject1", {31'd0, REJECT}, 1);
    checkOutput("t4_rejcnt1", {24'd0, REJECT_CNT}, 1);
    checkOutput("t4_noword1", {31'd0, INSTR_VALID}, 0);
    @(posedge CLK);
    #1;
    checkOutput("t4_reject_pulse", {31'd0, REJECT}, 0);
    applyStimulus(4'd0, 1'b1, 4'd0, 16'hFF7F);
    checkOutput("t4_reject2", {31'd0, REJECT}, 1);
    checkOutput("t4_rejcnt2", {24'd0, REJECT_CNT}, 2);
    checkOutput("t4_noword2", {31'd0, INSTR_VALID}, 0);

    // T5: fill with INSTR_READY low, then drain while the 5th waits
    for (int i = 1; i <= 4; i++) applyStimulus(4'd3, 1'b0, 4'(i), 16'd0);
    @(negedge CLK);
    checkOutput("t5_full_ready", {31'd0, REQ_READY}, 0);
    checkOutput("t5_hold_head", {16'd0, INSTRUCTION}, 16'hC831);
    @(negedge CLK);
    checkOutput("t5_hold_stable", {16'd0, INSTRUCTION}, 16'hC831);
    setRequest(4'd3, 1'b0, 4'd5, 16'd0);
    REQ_VALID   = 1'b1;
    INSTR_READY = 1'b1;
    seq[0] = 16'hC831; seq[1] = 16'hC832; seq[2] = 16'hC833;
    seq[3] = 16'hC834; seq[4] = 16'hC835;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t5_order%0d", i), {16'd0, INSTRUCTION}, {16'd0, seq[i]});
      if (i == 1) checkOutput("t5_space_ready", {31'd0, REQ_READY}, 1);
      @(posedge CLK);
      #1;
      if (i == 1) REQ_VALID = 1'b0;
      @(negedge CLK);
    end
    checkOutput("t5_drained", {31'd0, INSTR_VALID}, 0);
    INSTR_READY = 1'b0;

    // T6: FLUSH with a concurrent push
    for (int i = 1; i <= 3; i++) applyStimulus(4'd3, 1'b0, 4'(i), 16'd0);
    @(negedge CLK);
    FLUSH = 1'b1;
    setRequest(4'd3, 1'b0, 4'd9, 16'd0);
    REQ_VALID = 1'b1;
    #1;
    checkOutput("t6_flush_ready", {31'd0, REQ_READY}, 0);
    @(posedge CLK);
    #1;
    FLUSH     = 1'b0;
    REQ_VALID = 1'b0;
    checkOutput("t6_flush_valid", {31'd0, INSTR_VALID}, 0);
    checkOutput("t6_flush_instr", {16'd0, INSTRUCTION}, 0);
    checkOutput("t6_flush_rejcnt", {24'd0, REJECT_CNT}, 0);
    @(posedge CLK);
    #1;
    checkOutput("t6_flush_nopush", {31'd0, INSTR_VALID}, 0);

    // T6: RESET mid-stream while a REJECT pulse is live
    for (int i = 1; i <= 3; i++) applyStimulus(4'd3, 1'b0, 4'(i), 16'd0);
    applyStimulus(4'd5, 1'b1, 4'd0, 16'h0100);
    checkOutput("t6_pre_reject", {31'd0, REJECT}, 1);
    RESET = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'd0, INSTR_VALID}, 0);
    checkOutput("t6_rst_instr", {16'd0, INSTRUCTION}, 0);
    checkOutput("t6_rst_reject", {31'd0, REJECT}, 0);
    checkOutput("t6_rst_rejcnt", {24'd0, REJECT_CNT}, 0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checkOutput("t6_rst_ready", {31'd0, REQ_READY}, 1);
    applyStimulus(4'd0, 1'b1, 4'd0, 16'd10);
    expectPop("t6_after_rst", 16'hC90A);
    checkOutput("t6_after_rst_empty", {31'd0, INSTR_VALID}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
